// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount_stream pipeline.
// Optional parity output is enabled by defining POPCOUNT_PARITY_EN.
package popcount_pkg;

    typedef enum logic {
        MODE_ONES  = 1'b0,
        MODE_ZEROS = 1'b1
    } count_mode_e;

    // Bits needed to hold a count of 0..w set bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Add and clamp to the largest w-bit value (w < 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (65'd1 << w) - 65'd1;
        return 64'((sum > max) ? max : sum);
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational count of ones (or zeros) in one chunk of the input word.
// Bits at or above VALID_W are padding and never count, in either mode.
module popcount_chunk import popcount_pkg::*; #(
    parameter int CHUNK_W = 4,
    parameter int VALID_W = CHUNK_W,
    localparam int OUT_W  = cnt_width(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] chunk_i,
    input  count_mode_e        mode_i,
    output logic [OUT_W-1:0]   count_o
);

    localparam logic [CHUNK_W-1:0] MASK = {CHUNK_W{1'b1}} >> (CHUNK_W - VALID_W);

    logic [CHUNK_W-1:0] bits;

    // Invert for zeros mode, then drop padding so it counts as zero.
    always_comb begin
        bits    = (chunk_i ^ {CHUNK_W{mode_i == MODE_ZEROS}}) & MASK;
        count_o = '0;
        for (int b = 0; b < CHUNK_W; b++)
            count_o = count_o + OUT_W'(bits[b]);
    end

endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming ones/zeros counter with per-frame saturating sum.
// Stage 1 registers per-chunk counts, stage 2 sums them and accumulates.
// Define POPCOUNT_PARITY_EN to add a pipelined parity_out of each word.
module popcount_stream import popcount_pkg::*; #(
    parameter int DATA_W  = 7,
    parameter int CHUNK_W = 4,
    parameter int ACC_W   = 16,
    localparam int CNT_W  = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              mode,
    output logic [CNT_W-1:0]  count,
    output logic [ACC_W-1:0]  frame_sum,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
`ifdef POPCOUNT_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    localparam int NCH   = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W = NCH * CHUNK_W;
    localparam int CC_W  = cnt_width(CHUNK_W);

    logic                     en1, en2;
    logic [PAD_W-1:0]         data_pad;
    logic [NCH-1:0][CC_W-1:0] chunk_cnt_d, chunk_cnt_q;
    logic                     v1_q, last1_q;
    logic [CNT_W-1:0]         beat_cnt;
    logic [ACC_W-1:0]         sat_sum;
    logic [ACC_W-1:0]         acc_q;
    logic [CNT_W-1:0]         count_q;
    logic [ACC_W-1:0]         frame_sum_q;
    logic                     out_last_q, out_valid_q;

    // Stage 2 advances when it is empty or being drained; stage 1 also
    // advances when it is empty, so a bubble fills under a stall.
    assign en2      = !out_valid_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    // Zero-extend the word to a whole number of chunks.
    always_comb begin
        data_pad               = '0;
        data_pad[DATA_W-1:0]   = d_in;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        localparam int REM = DATA_W - g * CHUNK_W;
        localparam int VW  = (REM < CHUNK_W) ? REM : CHUNK_W;
        popcount_chunk #(
            .CHUNK_W (CHUNK_W),
            .VALID_W (VW)
        ) u_chunk (
            .chunk_i (data_pad[g*CHUNK_W +: CHUNK_W]),
            .mode_i  (count_mode_e'(mode)),
            .count_o (chunk_cnt_d[g])
        );
    end

    // Stage 1: capture chunk counts and frame marker on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            chunk_cnt_q <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                last1_q     <= in_last;
                chunk_cnt_q <= chunk_cnt_d;
            end
        end
    end

    // Reduce chunk counts to the beat count and form the clamped running sum.
    always_comb begin
        int unsigned sum;
        sum = 0;
        for (int i = 0; i < NCH; i++)
            sum = sum + 32'(chunk_cnt_q[i]);
        beat_cnt = CNT_W'(sum);
        sat_sum  = ACC_W'(sat_add(64'(acc_q), 64'(beat_cnt), ACC_W));
    end

    // Stage 2: present the beat and update the frame accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            count_q     <= '0;
            frame_sum_q <= '0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
        end else if (en2) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                count_q     <= beat_cnt;
                frame_sum_q <= sat_sum;
                out_last_q  <= last1_q;
                acc_q       <= last1_q ? '0 : sat_sum;
            end
        end
    end

    assign count     = count_q;
    assign frame_sum = frame_sum_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

`ifdef POPCOUNT_PARITY_EN
    logic par1_q, par_q;

    // Word parity rides the same enables as the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            par1_q <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            if (en1 && in_valid) par1_q <= ^d_in;
            if (en2 && v1_q)     par_q  <= par1_q;
        end
    end

    assign parity_out = par_q;
`endif

endmodule

// File: tb/tb_popcount_stream.sv
// Directed bench for popcount_stream: pipeline timing, zeros mode,
// backpressure, saturation (second instance with ACC_W = 4), mid-frame reset.
module tb_popcount_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] d_in;
    logic       in_valid, in_last, mode, out_ready;
    logic       rdy_a, rdy_b;
    logic [2:0] cnt_a, cnt_b;
    logic [15:0] fs_a;
    logic [3:0] fs_b;
    logic       last_a, last_b, vld_a, vld_b;
`ifdef POPCOUNT_PARITY_EN
    logic       par_a, par_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    popcount_stream #(.DATA_W(7), .CHUNK_W(4), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(rdy_a),
        .in_last(in_last), .mode(mode), .count(cnt_a), .frame_sum(fs_a),
        .out_last(last_a), .out_valid(vld_a), .out_ready(out_ready)
`ifdef POPCOUNT_PARITY_EN
        , .parity_out(par_a)
`endif
    );

    popcount_stream #(.DATA_W(7), .CHUNK_W(4), .ACC_W(4)) dut_b (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(rdy_b),
        .in_last(in_last), .mode(mode), .count(cnt_b), .frame_sum(fs_b),
        .out_last(last_b), .out_valid(vld_b), .out_ready(out_ready)
`ifdef POPCOUNT_PARITY_EN
        , .parity_out(par_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check all output fields of instance A.
    task automatic chk_a(input string tag, input logic v, input int c, input int fs, input logic l);
        chk({tag, ".valid"}, 32'(vld_a), 32'(v));
        chk({tag, ".count"}, 32'(cnt_a), c);
        chk({tag, ".sum"},   32'(fs_a),  fs);
        chk({tag, ".last"},  32'(last_a), 32'(l));
    endtask

    task automatic put(input logic [6:0] d, input logic m, input logic l);
        d_in = d; mode = m; in_last = l; in_valid = 1'b1;
    endtask

    task automatic idle();
        d_in = '0; mode = 1'b0; in_last = 1'b0; in_valid = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk_a("rst", 1'b0, 0, 0, 1'b0);
        chk("rst.ready", 32'(rdy_a), 1);

        // Basic pipeline, 2-cycle latency, frame of 5
        put(7'b0000001, 1'b0, 1'b0); step();
        chk("bas.v0", 32'(vld_a), 0);
        put(7'b0101001, 1'b0, 1'b0); step();
        chk_a("bas1", 1'b1, 1, 1, 1'b0);
`ifdef POPCOUNT_PARITY_EN
        chk("bas1.par", 32'(par_a), 1);
`endif
        put(7'b0111101, 1'b0, 1'b0); step();
        chk_a("bas2", 1'b1, 3, 4, 1'b0);
`ifdef POPCOUNT_PARITY_EN
        chk("bas2.par", 32'(par_a), 1);
`endif
        put(7'b1110101, 1'b0, 1'b0); step();
        chk_a("bas3", 1'b1, 5, 9, 1'b0);
`ifdef POPCOUNT_PARITY_EN
        chk("bas3.par", 32'(par_a), 1);
`endif
        put(7'b0010101, 1'b0, 1'b1); step();
        chk_a("bas4", 1'b1, 5, 14, 1'b0);
`ifdef POPCOUNT_PARITY_EN
        chk("bas4.par", 32'(par_a), 1);
`endif
        idle(); step();
        chk_a("bas5", 1'b1, 3, 17, 1'b1);
`ifdef POPCOUNT_PARITY_EN
        chk("bas5.par", 32'(par_a), 1);
`endif
        step();
        chk("bas.drain", 32'(vld_a), 0);

        // Zeros mode and boundaries, single-beat frames
        put(7'b0101001, 1'b1, 1'b1); step();
        put(7'b1111111, 1'b1, 1'b1); step();
        chk_a("zer1", 1'b1, 4, 4, 1'b1);
        put(7'b0000000, 1'b0, 1'b1); step();
        chk_a("zer2", 1'b1, 0, 0, 1'b1);
        put(7'b1111111, 1'b0, 1'b1); step();
        chk_a("zer3", 1'b1, 0, 0, 1'b1);
        put(7'b0000000, 1'b1, 1'b1); step();
        chk_a("one7", 1'b1, 7, 7, 1'b1);
        idle(); step();
        chk_a("zer7", 1'b1, 7, 7, 1'b1);
        step();

        // Backpressure: stall with both stages full
        put(7'b0000011, 1'b0, 1'b0); step();
        put(7'b0000111, 1'b0, 1'b0); step();
        chk_a("bp0", 1'b1, 2, 2, 1'b0);
`ifdef POPCOUNT_PARITY_EN
        chk("bp0.par", 32'(par_a), 0);
`endif
        out_ready = 1'b0;
        put(7'b0001111, 1'b0, 1'b0);
        #1;
        chk("bp.ready", 32'(rdy_a), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a("bp.hold", 1'b1, 2, 2, 1'b0);
            chk("bp.rdy", 32'(rdy_a), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rel", 32'(rdy_a), 1);
        step();
        chk_a("bp1", 1'b1, 3, 5, 1'b0);
        put(7'b0011111, 1'b0, 1'b1); step();
        chk_a("bp2", 1'b1, 4, 9, 1'b0);
        idle(); step();
        chk_a("bp3", 1'b1, 5, 14, 1'b1);
        step();
        chk("bp.drain", 32'(vld_a), 0);

        // Saturation on the ACC_W = 4 instance
        put(7'b1111111, 1'b0, 1'b0); step();
        put(7'b1111111, 1'b0, 1'b0); step();
        chk("sat1", 32'(fs_b), 7);
        put(7'b1111111, 1'b0, 1'b0); step();
        chk("sat2", 32'(fs_b), 14);
        put(7'b1111111, 1'b0, 1'b1); step();
        chk("sat3", 32'(fs_b), 15);
        chk("sat3.wide", 32'(fs_a), 21);
        put(7'b0000001, 1'b0, 1'b1); step();
        chk("sat4", 32'(fs_b), 15);
        chk("sat4.last", 32'(last_b), 1);
        idle(); step();
        chk("sat.next", 32'(fs_b), 1);
        chk("sat.cnt", 32'(cnt_b), 1);
        step();

        // Reset with two beats in flight
        put(7'b0000111, 1'b0, 1'b0); step();
        put(7'b0001111, 1'b0, 1'b0); step();
        chk_a("mr0", 1'b1, 3, 3, 1'b0);
        idle();
        rst = 1'b1; step();
        rst = 1'b0;
        chk_a("mr.rst", 1'b0, 0, 0, 1'b0);
        put(7'b0000001, 1'b0, 1'b1); step();
        chk("mr.empty", 32'(vld_a), 0);
        idle(); step();
        chk_a("mr1", 1'b1, 1, 1, 1'b1);
        step();
        chk("mr.drain", 32'(vld_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/popcount_stream.md
Name: popcount_stream

Overview:
- Parametrised, pipelined ones/zeros counter with valid/ready streaming handshake.
- Successor to the fixed 7-bit single-register ones counter: generic width, two-stage chunked adder pipeline, backpressure, count mode select, and saturating per-frame accumulation delimited by a last flag.
- Sits between a data producer and downstream statistics/threshold logic.

Parameters:
- DATA_W, 7, input word width (>=2).
- CHUNK_W, 4, stage-1 chunk width. The last chunk is zero-padded: padding counts as zero in both modes.
- ACC_W, 16, frame accumulator width (>= CNT_W).
- CNT_W, $clog2(DATA_W+1), derived localparam. Do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- d_in  in  DATA_W  input word.
- in_valid  in  1  d_in/in_last/mode valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_last  in  1  final beat of frame.
- mode  in  1  0 = count ones, 1 = count zeros; sampled with the beat.
- count  out  CNT_W  per-beat count.
- frame_sum  out  ACC_W  saturating running sum within the frame, including this beat.
- out_last  out  1  in_last delayed with the beat.
- out_valid  out  1  outputs valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- The reset requirement is fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid = 0, count = 0, frame_sum = 0, out_last = 0.
  - Internal v1 = 0, accumulator = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Stage 1 (register): per-chunk counts of ones, or of zeros when mode = 1, plus last and valid v1.
- Stage 2 (register): sum of chunk counts -> count; frame_sum; out_last; out_valid.
- Enables:
  - en2 = !out_valid || out_ready.
  - en1 = !v1 || en2.
  - in_ready = en1 (combinational, no dependence on in_valid).
- Latency:
  - An accepted beat appears at the outputs exactly 2 cycles later when there is no stall.
  - Throughput is 1 beat/cycle.
- Stall: while out_valid && !out_ready, count, frame_sum, out_last and out_valid are held stable.
- Bubbles:
  - A bubble in stage 1 is filled even while stage 2 is stalled (en1 true when !v1).
  - When en2 loads an empty stage 1, out_valid clears.
- Accumulator acc (ACC_W), updated only on a stage-2 load with v1 = 1:
  - s = min(acc + beat_count, 2^ACC_W-1).
  - frame_sum <= s.
  - acc <= in_last ? 0 : s.
- Saturation: once saturated, frame_sum stays at all-ones until the frame's last beat. The next frame starts from 0.
- Single-beat frame (in_last on the first beat): frame_sum = count.
- Reset mid-operation clears all pipeline contents and acc within one cycle. In-flight beats are dropped, not flushed.
- mode may change every beat. Each beat uses its own sampled mode.
- Boundary: all-ones word in mode 0 -> count = DATA_W; all-zeros word in mode 0 -> 0; mode 1 is the complement.

Optional Feature:
- Macro: POPCOUNT_PARITY_EN.
- Defined: adds output port parity_out (1 bit) = XOR of the sampled d_in bits (independent of mode). It is pipelined alongside count with the same latency, stall and reset (0) behaviour.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package popcount_pkg holds:
  - the count-mode enum (MODE_ONES = 0, MODE_ZEROS = 1);
  - a function computing the CNT_W width;
  - a saturating-add function for ACC_W.
- Sub-module popcount_chunk (combinational, CHUNK_W in, count out, mode in) is instantiated ceil(DATA_W/CHUNK_W) times in stage 1.

Test Plan:
- Basic pipeline (DATA_W = 7, mode 0, out_ready = 1):
  - Stimulus: 0000001, 0101001, 0111101, 1110101, 0010101 on consecutive cycles, in_last on the 5th.
  - Required: count = 1, 3, 5, 5, 3, each 2 cycles after input; frame_sum = 1, 4, 9, 14, 17; out_last on the 5th only.
- Zeros mode: 0101001 with mode = 1 -> count = 4. 1111111 with mode = 1 -> count = 0. 0000000 with mode = 0 -> 0.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 4 cycles mid-stream.
  - Required: outputs frozen; in_ready drops once both stages are full; no beat lost or duplicated; order and frame_sum preserved after release.
- Saturation: ACC_W = 4, four beats of 1111111 with in_last on the 4th -> frame_sum = 7, 14, 15, 15. The next frame's first beat 0000001 -> frame_sum = 1.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle with 2 beats in flight.
  - Required: out_valid = 0 the next cycle; the following frame's frame_sum starts from that beat's count.
- Parity (POPCOUNT_PARITY_EN defined): 0101001 -> parity_out = 1; 0111101 -> 1; 1110101 -> 1; 0010101 -> 1; 0000011 -> 0. All aligned with count.
